// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B over three external single-port memories.
// One multiply-accumulate per cycle; each C element costs P+2 cycles (P fetches, drain, write).
module matmul_ctrl #(
  parameter int N = 2,
  parameter int P = 4,
  parameter int M = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wrA_done,
  input  logic        wrB_done,
  output logic [7:0]  addrbA,
  input  logic [31:0] doutbA,
  output logic [7:0]  addrbB,
  input  logic [31:0] doutbB,
  output logic        weC,
  output logic [7:0]  addrC,
  output logic [31:0] dinC,
  output logic        busy,
  output logic        done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (P > 1) ? $clog2(P) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   acc_q, acc_d;
  logic          rvalid_q, rvalid_d;
  logic [7:0]    addr_a_q, addr_a_d;
  logic [7:0]    addr_b_q, addr_b_d;
  logic [7:0]    addr_c_q, addr_c_d;
  logic [31:0]   din_c_q, din_c_d;
  logic          we_c_q, we_c_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [31:0]   prod;
  logic [31:0]   acc_sum;
  logic [IW-1:0] next_i;
  logic [JW-1:0] next_j;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    din_c_d  = din_c_q;
    we_c_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = done_q;
    next_i   = i_q;
    next_j   = j_q;
    prod     = doutbA * doutbB;
    acc_sum  = acc_q + prod;
    // Read data lags its address by one cycle, so accumulate whenever the previous cycle fetched.
    rvalid_d = (state_q == S_FETCH);
    if (rvalid_q) acc_d = acc_sum;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (wrA_done && wrB_done) begin
          state_d  = S_FETCH;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          acc_d    = '0;
          addr_a_d = 8'd0;
          addr_b_d = 8'd0;
        end
      end
      S_FETCH: begin
        if (k_q == KW'(P - 1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + 1'b1;
          addr_a_d = 8'(32'(i_q) * P + 32'(k_q) + 1);
          addr_b_d = 8'((32'(k_q) + 1) * M + 32'(j_q));
        end
      end
      S_DRAIN: begin
        state_d  = S_WRITE;
        we_c_d   = 1'b1;
        addr_c_d = 8'(32'(i_q) * M + 32'(j_q));
        din_c_d  = acc_sum;
      end
      S_WRITE: begin
        acc_d = '0;
        k_d   = '0;
        if (j_q == JW'(M - 1)) begin
          next_j = '0;
          next_i = i_q + 1'b1;
        end else begin
          next_j = j_q + 1'b1;
        end
        if (j_q == JW'(M - 1) && i_q == IW'(N - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = S_FETCH;
          i_d      = next_i;
          j_d      = next_j;
          addr_a_d = 8'(32'(next_i) * P);
          addr_b_d = 8'(32'(next_j));
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rvalid_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      din_c_q  <= '0;
      we_c_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      rvalid_q <= rvalid_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
      din_c_q  <= din_c_d;
      we_c_q   <= we_c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign addrbA = addr_a_q;
  assign addrbB = addr_b_q;
  assign weC    = we_c_q;
  assign addrC  = addr_c_q;
  assign dinC   = din_c_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: memory models, expected C writes queued per run,
// and a negedge monitor that pops and compares every weC strobe.
module tb_matmul_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        wrA_done;
  logic        wrB_done;
  logic [7:0]  addrbA;
  logic [31:0] doutbA;
  logic [7:0]  addrbB;
  logic [31:0] doutbB;
  logic        weC;
  logic [7:0]  addrC;
  logic [31:0] dinC;
  logic        busy;
  logic        done;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  logic [39:0] sb_q [$];
  int          checks;
  int          errors;
  int          we_count;

  localparam logic [31:0] NOM_C [6] = '{32'd700, 32'd800, 32'd900, 32'd1580, 32'd1840, 32'd2100};

  matmul_ctrl #(.N(2), .P(4), .M(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wrA_done (wrA_done),
    .wrB_done (wrB_done),
    .addrbA   (addrbA),
    .doutbA   (doutbA),
    .addrbB   (addrbB),
    .doutbB   (doutbB),
    .weC      (weC),
    .addrC    (addrC),
    .dinC     (dinC),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge clk) begin
    doutbA <= mem_a[addrbA];
    doutbB <= mem_b[addrbB];
  end

  always @(negedge clk) begin
    logic [39:0] exp_w;
    if (!reset && weC) begin
      we_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write addrC=%0d dinC=%h, no write expected", addrC, dinC);
      end else begin
        exp_w = sb_q.pop_front();
        if ({addrC, dinC} !== exp_w) begin
          errors++;
          $display("[TB] FAIL c_write got addr=%0d data=%h, want addr=%0d data=%h",
                   addrC, dinC, exp_w[39:32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic load_nominal();
    for (int a = 0; a < 256; a++) begin
      mem_a[a] = (a < 8)  ? 32'(a + 1) : 32'd0;
      mem_b[a] = (a < 12) ? 32'(10 * (a + 1)) : 32'd0;
    end
  endtask

  task automatic push_expected(input int count, input bit wrap);
    for (int e = 0; e < count; e++)
      sb_q.push_back({8'(e), wrap ? 32'hFFFF_FFF8 : NOM_C[e]});
  endtask

  // Raise start and count edges until done; hammer keeps start high throughout the run.
  task automatic apply_stimulus(input string name, input int exp_edges, input bit hammer);
    int n;
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (!hammer) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check_output({name, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) check_output({name, "_cycles"}, 64'(n), 64'(exp_edges));
    check_output({name, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int base;
    int seen_we;
    bit bad;
    logic [7:0] hold_a;
    logic [7:0] hold_b;

    checks   = 0;
    errors   = 0;
    we_count = 0;
    start    = 1'b0;
    wrA_done = 1'b0;
    wrB_done = 1'b0;
    reset    = 1'b0;
    load_nominal();

    #1 reset = 1'b1;
    #1;
    check_output("reset_addrs", {addrbA, addrbB, addrC}, 64'd0);
    check_output("reset_dinC", 64'(dinC), 64'd0);
    check_output("reset_flags", {weC, busy, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_output("idle_after_reset", {weC, busy, done}, 64'd0);

    // Nominal run from IDLE.
    wrA_done = 1'b1;
    wrB_done = 1'b1;
    push_expected(6, 1'b0);
    apply_stimulus("nominal", 38, 1'b0);
    check_output("nominal_writes", 64'(we_count), 64'd6);

    // Second run from DONE with start held high the whole time.
    base = we_count;
    push_expected(6, 1'b0);
    apply_stimulus("hammer", 38, 1'b1);
    check_output("hammer_writes", 64'(we_count - base), 64'd6);
    repeat (3) @(posedge clk);
    #1 check_output("done_holds", {busy, done}, 64'b01);

    // Gating: only wrA ready, FSM must wait without touching the addresses.
    wrB_done = 1'b0;
    push_expected(6, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    hold_a = addrbA;
    hold_b = addrbB;
    bad    = 1'b0;
    base   = we_count;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!busy || done || weC || addrbA !== hold_a || addrbB !== hold_b) bad = 1'b1;
    end
    check_output("gate_wait_quiet", 64'(bad), 64'd0);
    check_output("gate_hold_addr", {hold_a, hold_b}, {8'd7, 8'd11});
    wrB_done = 1'b1;
    @(posedge clk); #1;
    check_output("gate_first_fetch", {addrbA, addrbB}, 64'h0000);
    @(posedge clk); #1;
    check_output("gate_second_fetch", {addrbA, addrbB}, {8'd1, 8'd3});
    begin
      int n;
      for (n = 3; n <= 400; n++) begin
        @(posedge clk); #1;
        if (done) break;
      end
      check_output("gate_cycles", 64'(n), 64'd37);
    end
    check_output("gate_writes", 64'(we_count - base), 64'd6);

    // Unsigned wrap-around of the accumulator.
    for (int a = 0; a < 8; a++)  mem_a[a] = 32'hFFFF_FFFF;
    for (int a = 0; a < 12; a++) mem_b[a] = 32'd2;
    push_expected(6, 1'b1);
    apply_stimulus("wrap", 38, 1'b0);

    // Reset during the third WRITE aborts the run for good.
    load_nominal();
    push_expected(3, 1'b0);
    base    = we_count;
    seen_we = 0;
    start   = 1'b1;
    for (int c = 0; c < 200 && seen_we < 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (weC) seen_we++;
    end
    reset = 1'b1;
    #1;
    check_output("abort_addrs", {addrbA, addrbB, addrC}, 64'd0);
    check_output("abort_dinC", 64'(dinC), 64'd0);
    check_output("abort_flags", {weC, busy, done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("abort_write_count_ok",
                 64'((we_count - base == 2) || (we_count - base == 3)), 64'd1);
    sb_q.delete();
    base = we_count;
    repeat (10) @(posedge clk);
    #1;
    check_output("abort_no_resume", {64'(we_count - base), busy, done}, 64'd0);

    push_expected(6, 1'b0);
    base = we_count;
    apply_stimulus("rerun", 38, 1'b0);
    check_output("rerun_writes", 64'(we_count - base), 64'd6);
    @(negedge clk);
    check_output("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
